fetch_sequencer: RTL and testbench

Controls instruction fetch for the processor. It owns the program counter and runs the fetch handshake with instruction memory. It holds each fetched instruction until the decode stage takes it. It then picks the next address: branch target, PC + 1, or stop on halt. It sits between the instruction memory port and the decode/execute stage and replaces the free-running PC update with a sequenced, stall-aware one.

---
 rtl/fetch_sequencer.sv | 95 +++++++++
 tb/tb_fetch_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - Stall-aware instruction fetch sequencer owning the program counter.
// Runs the imem request/ack handshake, holds each instruction for decode, then selects halt/branch/PC+1.
module fetch_sequencer #(
    parameter int                  PC_WIDTH    = 16,
    parameter int                  INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clock,
    input  logic                   restart_n,
    input  logic                   start,
    input  logic [PC_WIDTH-1:0]    start_pc,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [PC_WIDTH-1:0]    instr_pc,
    input  logic                   stall,
    input  logic                   branch,
    input  logic [PC_WIDTH-1:0]    target,
    input  logic                   halt,
    output logic                   halted,
    output logic [15:0]            fetch_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] next_pc;

    assign pc_inc  = pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    // Branch target feeds the next request directly, so redirects cost no extra cycle.
    assign next_pc = branch ? target : pc_inc;

    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            instr_pc    <= '0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        pc          <= start_pc;
                        imem_addr   <= start_pc;
                        imem_req    <= 1'b1;
                        halted      <= 1'b0;
                        fetch_count <= '0;
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr_out   <= imem_data;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
                        fetch_count <= fetch_count + 16'd1;
                        if (halt) begin
                            halted <= 1'b1;
                            state  <= HALTED;
                        end else begin
                            pc        <= next_pc;
                            imem_addr <= next_pc;
                            imem_req  <= 1'b1;
                            state     <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - Self-checking bench for fetch_sequencer: directed scenarios plus random traffic.
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        restart_n;
    logic        start;
    logic [15:0] start_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        instr_valid;
    logic [15:0] instr_out;
    logic [15:0] instr_pc;
    logic        stall;
    logic        branch;
    logic [15:0] target;
    logic        halt;
    logic        halted;
    logic [15:0] fetch_count;

    int n_cmp = 0;
    int n_err = 0;

    // Transaction-level reference: "waiting for memory", "holding an instruction", "stopped"
    bit          m_run;
    bit          m_req;
    bit          m_valid;
    bit          m_halted;
    logic [15:0] m_pc;
    logic [15:0] m_addr;
    logic [15:0] m_iout;
    logic [15:0] m_ipc;
    int          m_cnt;

    fetch_sequencer dut (
        .clock       (clock),
        .restart_n   (restart_n),
        .start       (start),
        .start_pc    (start_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .stall       (stall),
        .branch      (branch),
        .target      (target),
        .halt        (halt),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_req = 0; m_valid = 0; m_halted = 0;
        m_pc = 16'h0; m_addr = 16'h0; m_iout = 16'h0; m_ipc = 16'h0; m_cnt = 0;
    endtask

    task automatic model_step();
        if (!m_run) begin
            if (start) begin
                m_run = 1; m_halted = 0; m_cnt = 0;
                m_pc = start_pc; m_addr = start_pc; m_req = 1;
            end
        end else if (m_req) begin
            if (imem_ack) begin
                m_iout = imem_data; m_ipc = m_pc; m_valid = 1; m_req = 0;
            end
        end else if (m_valid && !stall) begin
            m_cnt = (m_cnt + 1) % 65536;
            m_valid = 0;
            if (halt) begin
                m_halted = 1; m_run = 0;
            end else begin
                m_pc = branch ? target : 16'((32'(m_pc) + 1) % 65536);
                m_addr = m_pc; m_req = 1;
            end
        end
    endtask

    task automatic check_all();
        check("imem_req", 32'(imem_req), 32'(m_req));
        if (m_req || !m_run) check("imem_addr", 32'(imem_addr), 32'(m_addr));
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
        if (m_valid) begin
            check("instr_out", 32'(instr_out), 32'(m_iout));
            check("instr_pc", 32'(instr_pc), 32'(m_ipc));
        end
        check("halted", 32'(halted), 32'(m_halted));
        check("fetch_count", 32'(fetch_count), 32'(m_cnt));
    endtask

    task automatic check_reset_values();
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr_out", 32'(instr_out), 32'd0);
        check("rst_instr_pc", 32'(instr_pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fetch_count", 32'(fetch_count), 32'd0);
    endtask

    task automatic cycle();
        @(posedge clock);
        if (!restart_n) model_reset();
        else model_step();
        #1;
        check_all();
        imem_data = 16'($urandom);
    endtask

    task automatic idle_inputs();
        start = 0; start_pc = 0; imem_ack = 0; imem_data = 16'($urandom);
        stall = 0; branch = 0; target = 0; halt = 0;
    endtask

    initial begin
        idle_inputs();
        restart_n = 0;
        model_reset();
        repeat (3) cycle();
        check_reset_values();
        restart_n = 1;
        cycle();

        start = 1; start_pc = 16'h0010;
        cycle();
        check("start_req", 32'(imem_req), 32'd1);
        check("start_addr", 32'(imem_addr), 32'h0010);
        start = 0;

        imem_ack = 1;
        repeat (5) cycle();
        check("seq_ipc", 32'(instr_pc), 32'h0012);
        branch = 1; target = 16'h0008;
        cycle();
        check("branch_addr", 32'(imem_addr), 32'h0008);
        check("count_3", 32'(fetch_count), 32'd3);

        imem_ack = 0; target = 16'h0055;
        cycle();
        branch = 0;
        repeat (2) cycle();
        check("wait_addr", 32'(imem_addr), 32'h0008);
        imem_ack = 1;
        cycle();
        imem_ack = 0; stall = 1;
        for (int i = 0; i < 4; i++) begin
            branch = 1'($urandom); halt = 1'($urandom); target = 16'($urandom);
            cycle();
        end
        check("stall_count", 32'(fetch_count), 32'd3);
        stall = 0; halt = 0; branch = 1; target = 16'h0020;
        cycle();
        branch = 0; imem_ack = 1;
        cycle();
        check("halt_ipc", 32'(instr_pc), 32'h0020);
        halt = 1; branch = 1; target = 16'h0030;
        cycle();
        check("halted", 32'(halted), 32'd1);
        halt = 0; branch = 0;
        repeat (3) cycle();
        check("halted_noreq", 32'(imem_req), 32'd0);
        start = 1; start_pc = 16'h0000;
        cycle();
        check("restart_count", 32'(fetch_count), 32'd0);
        check("restart_addr", 32'(imem_addr), 32'h0000);
        start = 0;

        cycle();
        branch = 1; target = 16'hFFFF;
        cycle();
        branch = 0;
        cycle();
        cycle();
        check("wrap_addr", 32'(imem_addr), 32'h0000);

        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 15) == 0);
            start_pc  = 16'($urandom);
            imem_ack  = ($urandom_range(0, 2) != 0);
            stall     = ($urandom_range(0, 2) == 0);
            branch    = ($urandom_range(0, 3) == 0);
            target    = 16'($urandom);
            halt      = ($urandom_range(0, 19) == 0);
            cycle();
        end

        begin
            int budget = 200;
            idle_inputs();
            start = 1; start_pc = 16'h1234;
            while (!imem_req && budget > 0) begin
                cycle();
                budget--;
            end
            check("req_before_reset", 32'(imem_req), 32'd1);
        end
        #2 restart_n = 0;
        #1;
        model_reset();
        check_reset_values();
        idle_inputs();
        repeat (2) cycle();
        restart_n = 1;
        cycle();
        check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
